cond_unit: RTL and testbench

- Consumer side of the ALU flag word {Z,N,C,V} (bit 3 = Z, 2 = N, 1 = C, 0 = V).
- Holds the architectural flag register and evaluates each instruction's 4-bit condition field against it.
- Gates register-write, memory-write and PC-select for conditionally executed instructions, and keeps executed/squashed counters.
- Sits in the execute stage between the ALU flag generator and writeback/fetch control.

---
 rtl/cond_pkg.sv | 33 +++
 rtl/cond_check.sv | 44 ++++
 rtl/cond_unit.sv | 78 +++++++
 tb/tb_cond_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// cond_pkg: shared condition encodings and flag bit positions for the condition unit.
// Contents: cond_e (16 condition encodings), flag word bit indices {Z,N,C,V},
// and FlagW bit indices selecting which flag pairs an instruction updates.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGW_ZN = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// cond_check: combinational evaluation of a 4-bit condition field against a flag word.
// Ports: Cond (condition field), Flags ({Z,N,C,V}) -> condtrue (condition holds).
// The reserved encoding F never holds.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       condtrue
);

    logic z, n, c, v;
    cond_e cc;

    assign z  = Flags[FLAG_Z];
    assign n  = Flags[FLAG_N];
    assign c  = Flags[FLAG_C];
    assign v  = Flags[FLAG_V];
    assign cc = cond_e'(Cond);

    always_comb begin
        condtrue = 1'b0;
        case (cc)
            COND_EQ: condtrue = z;
            COND_NE: condtrue = ~z;
            COND_CS: condtrue = c;
            COND_CC: condtrue = ~c;
            COND_MI: condtrue = n;
            COND_PL: condtrue = ~n;
            COND_VS: condtrue = v;
            COND_VC: condtrue = ~v;
            COND_HI: condtrue = c & ~z;
            COND_LS: condtrue = ~c | z;
            COND_GE: condtrue = n == v;
            COND_LT: condtrue = n != v;
            COND_GT: condtrue = ~z & (n == v);
            COND_LE: condtrue = z | (n != v);
            COND_AL: condtrue = 1'b1;
            COND_NV: condtrue = 1'b0;
            default: condtrue = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// cond_unit: execute-stage condition unit; holds the architectural flag register,
// gates register/memory/PC writes of conditionally executed instructions, and
// counts executed and condition-failed instructions with saturating counters.
// Ports: clk, reset (async, active-high); en (advance), flush, valid_in;
// Cond, ALUFlags, FlagW, RegW, MemW, PCS, NoWrite, clr_cnt in;
// CondEx, RegWrite, MemWrite, PCSrc, Flags, exec_cnt, squash_cnt out.
module cond_unit
    import cond_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             valid_in,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             PCS,
    input  logic             NoWrite,
    input  logic             clr_cnt,
    output logic             CondEx,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             PCSrc,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] exec_q, exec_d, squash_q, squash_d;
    logic             condtrue, commit, adv;

    // Condition is judged on the registered flags only; a flag-setting
    // instruction therefore sees the old flags for its own condition.
    cond_check u_check (
        .Cond     (Cond),
        .Flags    (flags_q),
        .condtrue (condtrue)
    );

    assign CondEx   = valid_in & ~flush & condtrue;
    assign commit   = CondEx & en;
    assign adv      = valid_in & en & ~flush;
    assign RegWrite = RegW & ~NoWrite & commit;
    assign MemWrite = MemW & commit;
    assign PCSrc    = PCS & commit;

    always_comb begin
        flags_d = flags_q;
        flags_d[FLAG_Z:FLAG_N] = (commit & FlagW[FLAGW_ZN]) ? ALUFlags[FLAG_Z:FLAG_N] : flags_q[FLAG_Z:FLAG_N];
        flags_d[FLAG_C:FLAG_V] = (commit & FlagW[FLAGW_CV]) ? ALUFlags[FLAG_C:FLAG_V] : flags_q[FLAG_C:FLAG_V];
        // Clear wins over a same-cycle increment; counters stick at all-ones.
        exec_d   = clr_cnt ? '0 : (adv & condtrue & ~&exec_q) ? exec_q + CNT_W'(1) : exec_q;
        squash_d = clr_cnt ? '0 : (adv & ~condtrue & ~&squash_q) ? squash_q + CNT_W'(1) : squash_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q  <= 4'b0000;
            exec_q   <= '0;
            squash_q <= '0;
        end else begin
            flags_q  <= flags_d;
            exec_q   <= exec_d;
            squash_q <= squash_d;
        end
    end

    assign Flags      = flags_q;
    assign exec_cnt   = exec_q;
    assign squash_cnt = squash_q;

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: table-driven directed bench for cond_unit (CNT_W=4), plus
// hand sequences for counter saturation, clear priority, flush and async reset.
module tb_cond_unit;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset, en, flush, valid_in, RegW, MemW, PCS, NoWrite, clr_cnt;
    logic [3:0]    Cond, ALUFlags;
    logic [1:0]    FlagW;
    logic          CondEx, RegWrite, MemWrite, PCSrc;
    logic [3:0]    Flags;
    logic [CW-1:0] exec_cnt, squash_cnt;

    int checks = 0;
    int errors = 0;

    cond_unit #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .flush      (flush),
        .valid_in   (valid_in),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .FlagW      (FlagW),
        .RegW       (RegW),
        .MemW       (MemW),
        .PCS        (PCS),
        .NoWrite    (NoWrite),
        .clr_cnt    (clr_cnt),
        .CondEx     (CondEx),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .PCSrc      (PCSrc),
        .Flags      (Flags),
        .exec_cnt   (exec_cnt),
        .squash_cnt (squash_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] cond;
        logic [2:0] vef;
        logic [1:0] fw;
        logic [3:0] alu;
        logic [4:0] ctl;
        logic [3:0] out;
        logic [3:0] flg;
        logic [3:0] ec;
        logic [3:0] sc;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [3:0] cond, input logic [2:0] vef, input logic [1:0] fw,
                                input logic [3:0] alu, input logic [4:0] ctl, input logic [3:0] out,
                                input logic [3:0] flg, input logic [3:0] ec, input logic [3:0] sc);
        return '{cond, vef, fw, alu, ctl, out, flg, ec, sc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [2:0] vef, input logic [1:0] fw,
                         input logic [3:0] alu, input logic [4:0] ctl);
        Cond = c;
        {valid_in, en, flush} = vef;
        FlagW = fw;
        ALUFlags = alu;
        {RegW, MemW, PCS, NoWrite, clr_cnt} = ctl;
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        drive(v.cond, v.vef, v.fw, v.alu, v.ctl);
        #1;
        chk($sformatf("v%0d CondEx", idx), 32'(CondEx), 32'(v.out[3]));
        chk($sformatf("v%0d RegWrite", idx), 32'(RegWrite), 32'(v.out[2]));
        chk($sformatf("v%0d MemWrite", idx), 32'(MemWrite), 32'(v.out[1]));
        chk($sformatf("v%0d PCSrc", idx), 32'(PCSrc), 32'(v.out[0]));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d Flags", idx), 32'(Flags), 32'(v.flg));
        chk($sformatf("v%0d exec_cnt", idx), 32'(exec_cnt), 32'(v.ec));
        chk($sformatf("v%0d squash_cnt", idx), 32'(squash_cnt), 32'(v.sc));
    endtask

    initial begin
        int e;
        // cond, {vld,en,fl}, FlagW, ALUFlags, {RegW,MemW,PCS,NoWrite,clr},
        // {CondEx,RegWrite,MemWrite,PCSrc}, Flags after, exec after, squash after
        vecs[0]  = mk(4'h0, 3'b110, 2'b00, 4'h0, 5'b10000, 4'b0000, 4'h0, 4'd0,  4'd1);
        vecs[1]  = mk(4'h1, 3'b110, 2'b00, 4'h0, 5'b10000, 4'b1100, 4'h0, 4'd1,  4'd1);
        vecs[2]  = mk(4'hE, 3'b110, 2'b11, 4'h8, 5'b00000, 4'b1000, 4'h8, 4'd2,  4'd1);
        vecs[3]  = mk(4'h0, 3'b110, 2'b00, 4'h0, 5'b10000, 4'b1100, 4'h8, 4'd3,  4'd1);
        vecs[4]  = mk(4'hE, 3'b110, 2'b11, 4'h5, 5'b00000, 4'b1000, 4'h5, 4'd4,  4'd1);
        vecs[5]  = mk(4'hA, 3'b110, 2'b00, 4'h0, 5'b00000, 4'b1000, 4'h5, 4'd5,  4'd1);
        vecs[6]  = mk(4'hB, 3'b110, 2'b00, 4'h0, 5'b00000, 4'b0000, 4'h5, 4'd5,  4'd2);
        vecs[7]  = mk(4'hC, 3'b110, 2'b00, 4'h0, 5'b00000, 4'b1000, 4'h5, 4'd6,  4'd2);
        vecs[8]  = mk(4'hD, 3'b110, 2'b00, 4'h0, 5'b00000, 4'b0000, 4'h5, 4'd6,  4'd3);
        vecs[9]  = mk(4'hE, 3'b110, 2'b11, 4'h0, 5'b00000, 4'b1000, 4'h0, 4'd7,  4'd3);
        vecs[10] = mk(4'hE, 3'b110, 2'b01, 4'hF, 5'b00000, 4'b1000, 4'h3, 4'd8,  4'd3);
        vecs[11] = mk(4'h8, 3'b110, 2'b00, 4'h0, 5'b00100, 4'b1001, 4'h3, 4'd9,  4'd3);
        vecs[12] = mk(4'h9, 3'b110, 2'b00, 4'h0, 5'b00100, 4'b0000, 4'h3, 4'd9,  4'd4);
        vecs[13] = mk(4'h2, 3'b110, 2'b00, 4'h0, 5'b10010, 4'b1000, 4'h3, 4'd10, 4'd4);
        vecs[14] = mk(4'hF, 3'b110, 2'b00, 4'h0, 5'b00000, 4'b0000, 4'h3, 4'd10, 4'd5);
        vecs[15] = mk(4'h7, 3'b110, 2'b00, 4'h0, 5'b00000, 4'b0000, 4'h3, 4'd10, 4'd6);
        vecs[16] = mk(4'hE, 3'b111, 2'b11, 4'hF, 5'b01000, 4'b0000, 4'h3, 4'd10, 4'd6);
        vecs[17] = mk(4'hE, 3'b010, 2'b11, 4'hF, 5'b10000, 4'b0000, 4'h3, 4'd10, 4'd6);
        vecs[18] = mk(4'hE, 3'b100, 2'b11, 4'hC, 5'b01000, 4'b1000, 4'h3, 4'd10, 4'd6);
        vecs[19] = mk(4'hE, 3'b100, 2'b11, 4'hC, 5'b01000, 4'b1000, 4'h3, 4'd10, 4'd6);
        vecs[20] = mk(4'hE, 3'b100, 2'b11, 4'hC, 5'b01000, 4'b1000, 4'h3, 4'd10, 4'd6);
        vecs[21] = mk(4'hE, 3'b110, 2'b11, 4'hC, 5'b01000, 4'b1010, 4'hC, 4'd11, 4'd6);
        vecs[22] = mk(4'h4, 3'b110, 2'b00, 4'h0, 5'b00000, 4'b1000, 4'hC, 4'd12, 4'd6);
        vecs[23] = mk(4'h6, 3'b110, 2'b00, 4'h0, 5'b00000, 4'b0000, 4'hC, 4'd12, 4'd7);
        vecs[24] = mk(4'h3, 3'b110, 2'b00, 4'h0, 5'b00000, 4'b1000, 4'hC, 4'd13, 4'd7);
        vecs[25] = mk(4'h5, 3'b110, 2'b00, 4'h0, 5'b00000, 4'b0000, 4'hC, 4'd13, 4'd8);
        vecs[26] = mk(4'h0, 3'b110, 2'b00, 4'h0, 5'b10000, 4'b1100, 4'hC, 4'd14, 4'd8);

        reset = 1'b1;
        drive(4'h0, 3'b000, 2'b00, 4'h0, 5'b00000);
        repeat (2) @(posedge clk);
        #1;
        chk("reset Flags", 32'(Flags), 32'h0);
        chk("reset exec_cnt", 32'(exec_cnt), 32'h0);
        chk("reset squash_cnt", 32'(squash_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) apply(vecs[i], i);

        // Saturation: exec_cnt starts at 14, climbs to 15 and sticks.
        e = 14;
        for (int i = 0; i < 20; i++) begin
            e = (e < 15) ? e + 1 : 15;
            apply(mk(4'hE, 3'b110, 2'b00, 4'h0, 5'b00000, 4'b1000, 4'hC, 4'(e), 4'd8), 100 + i);
        end
        chk("saturated exec_cnt", 32'(exec_cnt), 32'd15);
        // Clear beats a same-cycle increment, then flush leaves everything alone.
        apply(mk(4'hE, 3'b110, 2'b00, 4'h0, 5'b00001, 4'b1000, 4'hC, 4'd0, 4'd0), 200);
        apply(mk(4'hE, 3'b111, 2'b11, 4'h3, 5'b11100, 4'b0000, 4'hC, 4'd0, 4'd0), 201);
        apply(mk(4'hF, 3'b110, 2'b00, 4'h0, 5'b00000, 4'b0000, 4'hC, 4'd0, 4'd1), 202);
        apply(mk(4'hE, 3'b110, 2'b00, 4'h0, 5'b00000, 4'b1000, 4'hC, 4'd1, 4'd1), 203);

        // Asynchronous reset mid-stall, away from any clock edge.
        @(negedge clk);
        drive(4'hE, 3'b101, 2'b11, 4'hF, 5'b01000);
        #2 reset = 1'b1;
        #1;
        chk("async reset Flags", 32'(Flags), 32'h0);
        chk("async reset exec_cnt", 32'(exec_cnt), 32'h0);
        chk("async reset squash_cnt", 32'(squash_cnt), 32'h0);
        chk("reset-stall MemWrite", 32'(MemWrite), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
